// File: rtl/mux_n_reg.sv
// N-channel registered select mux with direct and round-robin scan modes.
// Reports out-of-range selects, a capture strobe and a scan-wrap strobe.
module mux_n_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   In,
    input  logic [SELW-1:0]      Sel,
    input  logic                 Mode,
    input  logic                 En,
    output logic [WIDTH-1:0]     Out,
    output logic                 OutValid,
    output logic [SELW-1:0]      CurSel,
    output logic                 SelErr,
    output logic                 Wrap
);

    generate
        if (N < 2 || N > 256 || (1 << SELW) < N) begin : g_bad_params
            $error("mux_n_reg: need 2 <= N <= 256 and 2**SELW >= N");
        end
    endgenerate

    localparam logic [SELW:0]   NUM  = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0]  cnt;
    logic [SELW-1:0]  cnt_next;
    logic [SELW-1:0]  eff_cnt;
    logic [SELW-1:0]  sel_idx;
    logic             mode_q;
    logic             sel_bad;
    logic             at_last;
    logic [WIDTH-1:0] mux_data;

    // Entering scan mode restarts the walk at channel 0 in that same cycle.
    always_comb begin
        eff_cnt  = (Mode && !mode_q) ? '0 : cnt;
        sel_idx  = Mode ? eff_cnt : Sel;
        sel_bad  = !Mode && ({1'b0, Sel} >= NUM);
        at_last  = (eff_cnt == LAST);
        cnt_next = Mode ? eff_cnt : cnt;
        if (Mode && En) begin
            cnt_next = at_last ? '0 : eff_cnt + 1'b1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise an incomplete if/loop infers a latch.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_idx == SELW'(k)) begin
                mux_data = In[k*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Out      <= '0;
            OutValid <= 1'b0;
            CurSel   <= '0;
            SelErr   <= 1'b0;
            Wrap     <= 1'b0;
            cnt      <= '0;
            mode_q   <= 1'b0;
        end else begin
            mode_q   <= Mode;
            cnt      <= cnt_next;
            OutValid <= En;
            if (En) begin
                Out    <= mux_data;
                CurSel <= sel_idx;
                SelErr <= sel_bad;
                Wrap   <= Mode && at_last;
            end
        end
    end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised successor to the datapath's 16-bit 8:1 select mux.
- Selects one of N WIDTH-bit channels and registers the result, with one cycle of latency.
- Two modes: direct select, or an automatic round-robin scan mode driven by an internal counter. Scan mode walks all channels for debug and register-file readout.
- Also reports an out-of-range select, a valid strobe and a scan-wrap strobe, so the control unit can sequence it without extra logic.

Parameters:
- WIDTH, 16, bit width of each channel.
- N, 8, number of input channels (2..256).
- SELW, 3, select width; the build must satisfy 2^SELW >= N, otherwise elaboration is an error.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- In  input  N*WIDTH  flattened channels; channel k = In[k*WIDTH +: WIDTH].
- Sel  input  SELW  channel select, used in direct mode only.
- Mode  input  1  0 = direct, 1 = scan.
- En  input  1  capture enable.
- Out  output  WIDTH  registered selected channel.
- OutValid  output  1  high for the cycle after a capture.
- CurSel  output  SELW  channel index held in Out.
- SelErr  output  1  last capture used an out-of-range Sel.
- Wrap  output  1  last capture was channel N-1 in scan mode.

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - Out=0, OutValid=0, CurSel=0, SelErr=0, Wrap=0.
  - Scan counter cnt=0; previous-mode register mode_q=0.
- All other state changes on the rising edge of CLK only. The mux path is combinational into the Out register; latency is 1 cycle from En to Out/OutValid.
- En=0:
  - Out, CurSel, SelErr and Wrap hold their values.
  - OutValid<=0; cnt holds.
- Direct mode (Mode=1'b0, En=1):
  - Sel<N: Out<=channel Sel, CurSel<=Sel, SelErr<=0.
  - Sel>=N (possible only when N<2^SELW): Out<=0, CurSel<=Sel, SelErr<=1.
  - OutValid<=1, Wrap<=0, cnt unchanged.
- Scan mode (Mode=1, En=1):
  - Out<=channel cnt, CurSel<=cnt, SelErr<=0, OutValid<=1.
  - cnt<=(cnt==N-1)?0:cnt+1.
  - Wrap<=(cnt==N-1).
  - Sel is ignored.
- Mode entry: mode_q<=Mode every cycle, regardless of En.
  - On a 0->1 transition (Mode=1, mode_q=0), the effective cnt for that cycle is 0. The capture (if En=1) uses channel 0 and the next cnt is 1; if En=0 the next cnt is 0.
  - Leaving scan mode (1->0) does not alter cnt; re-entry restarts at 0 per the rule above.
- Wrap and SelErr are per-capture flags, not sticky; the next capture overwrites them.
- Channel inputs may change every cycle. Out reflects the value present at the capturing edge only.
- Width rule: no arithmetic on data. The cnt compare and increment are SELW bits wide, and the wrap compare against N-1 is exact, so non-power-of-2 N wraps correctly.

Test Plan (WIDTH=16, N=6, SELW=3; channel k = 16'hA000+k unless noted):
1. Reset then direct mode, En=1, Sel=3 -> next cycle Out=16'hA003, CurSel=3, OutValid=1, SelErr=0. En=0 next cycle -> Out holds 16'hA003, OutValid=0.
2. Direct mode, Sel=7 (out of range), En=1 -> Out=16'h0000, CurSel=7, SelErr=1. Following capture with Sel=0 -> Out=16'hA000, SelErr=0.
3. Mode 0->1 with En=1 for 8 consecutive cycles -> Out sequence A000, A001, A002, A003, A004, A005, A000, A001. Wrap=1 only in the cycle Out=A005. OutValid=1 throughout.
4. Scan with En toggling 1,0,1,0 -> Out A000, hold, A001, hold; OutValid 1,0,1,0; cnt does not advance on En=0 cycles.
5. Mid-scan reset asserted asynchronously between edges after Out=A003 -> all outputs 0 immediately, before the next edge. Release with Mode=1, En=1 -> first Out=A000.
6. Scan to Out=A002, switch Mode=0 with Sel=5 -> Out=A005, Wrap=0. Return to Mode=1 -> first scan Out=A000, not A003.
